// File: rtl/od_bus_pkg.sv
// Shared definitions for the open-drain bus receiver: filter limits, counter type
// and the 0/1/z/x line resolution used ahead of the synchroniser.
package od_bus_pkg;

    localparam int OD_FILTER_MAX = 15;

    typedef logic [$clog2(OD_FILTER_MAX + 1) - 1:0] od_cnt_t;

    // Pulled-up wired-AND line: z reads as released, a contended (x) line reads as low.
    function automatic logic resolve_od(input logic v);
        return (v === 1'b1) || (v === 1'bz);
    endfunction

endpackage

// File: rtl/od_rx_chan.sv
// One open-drain receive channel: resolve, two-flop sync, glitch filter, edge pulses
// and, with OD_BUS_RECEIVER_EVENT_LATCH_EN, a sticky assertion flag.
module od_rx_chan
    import od_bus_pkg::*;
#(
    parameter int FILTER = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic y,
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
    input  logic ack,
    output logic evt,
`endif
    output logic lvl,
    output logic fall,
    output logic rise
);

    localparam int CW = $clog2(FILTER + 1);

    logic          s1;
    logic          s2;
    logic          lvl_prev;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (s2 != lvl) && (cnt == CW'(FILTER - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            lvl      <= 1'b1;
            lvl_prev <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
            rise     <= 1'b0;
        end else begin
            // sync stage
            s1 <= resolve_od(y);
            s2 <= s1;
            // filter stage: cnt tracks how long s2 has disagreed with lvl
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (accept) begin
                lvl <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // edge stage: compare lvl against its value one edge earlier
            lvl_prev <= lvl;
            fall     <= lvl_prev & ~lvl;
            rise     <= ~lvl_prev & lvl;
        end
    end

`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
    // Set on the edge lvl is accepted low; set beats a simultaneous ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            evt <= 1'b0;
        end else if (accept && !s2) begin
            evt <= 1'b1;
        end else if (ack) begin
            evt <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/od_bus_receiver.sv
// Multi-channel open-drain bus receiver. Optional event latch (ack/evt/irq) is
// compiled in with OD_BUS_RECEIVER_EVENT_LATCH_EN.
module od_bus_receiver
    import od_bus_pkg::*;
#(
    parameter int CHANNELS = 6,
    parameter int FILTER   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vcc,
    input  logic                gnd,
    input  logic [CHANNELS-1:0] y,
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] evt,
    output logic                irq,
`endif
    output logic [CHANNELS-1:0] lvl,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rise
);

    // Power pins exist only so the netlist matches the component model.
    logic unused_pwr;
    assign unused_pwr = vcc ^ gnd;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        od_rx_chan #(
            .FILTER(FILTER)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .y   (y[i]),
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
            .ack (ack[i]),
            .evt (evt[i]),
`endif
            .lvl (lvl[i]),
            .fall(fall[i]),
            .rise(rise[i])
        );
    end

`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
    assign irq = |evt;
`endif

endmodule

// File: tb/tb_od_bus_receiver.sv
// Self-checking bench for od_bus_receiver: directed scenarios plus random traffic
// against a window-based reference model of the filtered bus.
module tb_od_bus_receiver;

    localparam int CH = 6;
    localparam int F  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vcc = 1'b1;
    logic          gnd = 1'b0;
    logic [CH-1:0] y   = '1;
    logic [CH-1:0] ack = '0;
    logic [CH-1:0] lvl, fall, rise;
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
    logic [CH-1:0] evt;
    logic          irq;
`endif

    int tests_run = 0;
    int failed    = 0;

    od_bus_receiver #(.CHANNELS(CH), .FILTER(F)) u_dut (
        .clk (clk),
        .rst (rst),
        .vcc (vcc),
        .gnd (gnd),
        .y   (y),
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
        .ack (ack),
        .evt (evt),
        .irq (irq),
`endif
        .lvl (lvl),
        .fall(fall),
        .rise(rise)
    );

    always #5 clk = ~clk;

    // Reference model: the line must disagree with lvl for the last F
    // synchronised observations (seen two edges after sampling) to be accepted.
    bit [CH-1:0] m_lvl  = '1;
    bit [CH-1:0] m_prev = '1;
    bit [CH-1:0] m_fall = '0;
    bit [CH-1:0] m_rise = '0;
    bit [CH-1:0] m_evt  = '0;
    bit          hist [CH][$];
    bit          win  [CH][$];

    function automatic bit res(logic v);
        return !((v === 1'b0) || (v === 1'bx));
    endfunction

    task automatic model_update();
        bit [CH-1:0] nl;
        bit obs;
        bit agree;
        if (!rst) begin
            m_lvl = '1; m_prev = '1; m_fall = '0; m_rise = '0; m_evt = '0;
            for (int c = 0; c < CH; c++) begin
                hist[c].delete();
                win[c].delete();
            end
        end else begin
            nl = m_lvl;
            for (int c = 0; c < CH; c++) begin
                obs = (hist[c].size() >= 2) ? hist[c][hist[c].size() - 2] : 1'b1;
                hist[c].push_back(res(y[c]));
                if (hist[c].size() > 2) void'(hist[c].pop_front());
                win[c].push_back(obs);
                if (win[c].size() > F) void'(win[c].pop_front());
                agree = (win[c].size() == F);
                foreach (win[c][k]) if (win[c][k] == m_lvl[c]) agree = 0;
                if (agree) begin
                    nl[c] = ~m_lvl[c];
                    win[c].delete();
                end
            end
            m_fall = m_prev & ~m_lvl;
            m_rise = ~m_prev & m_lvl;
            for (int c = 0; c < CH; c++) begin
                if (m_lvl[c] && !nl[c]) m_evt[c] = 1'b1;
                else if (ack[c])        m_evt[c] = 1'b0;
            end
            m_prev = m_lvl;
            m_lvl  = nl;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; y = 'z; ack = '0;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (lvl !== 6'b111111) begin failed++; $display("FAIL reset_lvl got=%b exp=%b", lvl, 6'b111111); end
        tests_run++;
        if (fall !== '0 || rise !== '0) begin failed++; $display("FAIL reset_edges fall=%b rise=%b exp=0", fall, rise); end
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
        tests_run++;
        if (evt !== '0 || irq !== 1'b0) begin failed++; $display("FAIL reset_evt evt=%b irq=%b exp=0", evt, irq); end
`endif
        y = '1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (lvl !== 6'b111111 || rise !== '0 || fall !== '0) begin
                failed++; $display("FAIL idle_after_reset lvl=%b rise=%b fall=%b exp=111111/0/0", lvl, rise, fall);
            end
        end
    endtask

    task automatic test_clean_assert();
        y[0] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            tests_run++;
            if (lvl[0] !== ((e >= 1 + F) ? 1'b0 : 1'b1)) begin
                failed++; $display("FAIL clean_lvl edge=%0d got=%b exp=%b", e, lvl[0], (e >= 1 + F) ? 1'b0 : 1'b1);
            end
            tests_run++;
            if (fall[0] !== (e == 2 + F)) begin
                failed++; $display("FAIL clean_fall edge=%0d got=%b exp=%b", e, fall[0], (e == 2 + F));
            end
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
            tests_run++;
            if (evt[0] !== (e >= 1 + F) || irq !== (e >= 1 + F)) begin
                failed++; $display("FAIL clean_evt edge=%0d evt=%b irq=%b exp=%b", e, evt[0], irq, (e >= 1 + F));
            end
`endif
        end
        y[0] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            tests_run++;
            if (rise[0] !== (e == 2 + F) || fall[0] !== 1'b0) begin
                failed++; $display("FAIL clean_rise edge=%0d rise=%b fall=%b exp=%b/0", e, rise[0], fall[0], (e == 2 + F));
            end
        end
    endtask

    task automatic test_glitch();
        // Two short pulses separated by one released sample: neither may be accepted.
        bit pat [9] = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
        for (int e = 0; e < 9; e++) begin
            y[2] = pat[e];
            tick();
        end
        for (int e = 0; e < 12; e++) begin
            tick();
            tests_run++;
            if (lvl[2] !== 1'b1 || fall[2] !== 1'b0 || rise[2] !== 1'b0) begin
                failed++; $display("FAIL glitch edge=%0d lvl=%b fall=%b rise=%b exp=1/0/0", e, lvl[2], fall[2], rise[2]);
            end
        end
    endtask

    task automatic test_x_indep();
        y[3] = 1'bx; y[4] = 1'b0;
        for (int e = 0; e < 12; e++) begin
            if (e == 5) begin y[3] = 1'b1; y[4] = 1'b1; end
            tick();
            tests_run++;
            if (lvl !== m_lvl || fall !== m_fall || rise !== m_rise) begin
                failed++; $display("FAIL x_indep edge=%0d lvl=%b/%b fall=%b/%b rise=%b/%b (got/exp)",
                                   e, lvl, m_lvl, fall, m_fall, rise, m_rise);
            end
            tests_run++;
            if (lvl[4] !== ((e >= 1 + F && e < 6 + F) ? 1'b0 : 1'b1)) begin
                failed++; $display("FAIL x_indep_ch4 edge=%0d got=%b", e, lvl[4]);
            end
        end
    endtask

`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
    task automatic test_ack();
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        tests_run++;
        if (evt[0] !== 1'b0) begin failed++; $display("FAIL ack_clear got=%b exp=0", evt[0]); end
        ack[1] = 1'b1; y[1] = 1'b0;
        for (int e = 0; e < 7; e++) begin
            tick();
            tests_run++;
            if (evt[1] !== (e == 1 + F)) begin
                failed++; $display("FAIL ack_set_wins edge=%0d got=%b exp=%b", e, evt[1], (e == 1 + F));
            end
        end
        y[1] = 1'b1;
        for (int e = 0; e < 6; e++) tick();
        ack[1] = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        y[5] = 1'b0;
        for (int e = 0; e < 3; e++) tick();
        rst = 1'b0; ack = '1;
        tick(); tick();
        tests_run++;
        if (lvl[5] !== 1'b1 || fall[5] !== 1'b0) begin
            failed++; $display("FAIL reset_mid lvl=%b fall=%b exp=1/0", lvl[5], fall[5]);
        end
        rst = 1'b1; ack = '0;
        for (int e = 0; e < 8; e++) begin
            tick();
            tests_run++;
            if (fall[5] !== (e == 2 + F) || lvl[5] !== ((e >= 1 + F) ? 1'b0 : 1'b1)) begin
                failed++; $display("FAIL reset_mid_fall edge=%0d fall=%b lvl=%b exp=%b/%b",
                                   e, fall[5], lvl[5], (e == 2 + F), (e >= 1 + F) ? 1'b0 : 1'b1);
            end
        end
        y[5] = 1'b1;
        for (int e = 0; e < 8; e++) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(3) == 0) y[c] = ~y[c];
                ack[c] = ($urandom_range(7) == 0);
            end
            tick();
            tests_run++;
            if (lvl !== m_lvl || fall !== m_fall || rise !== m_rise) begin
                failed++; $display("FAIL random n=%0d lvl=%b/%b fall=%b/%b rise=%b/%b (got/exp)",
                                   n, lvl, m_lvl, fall, m_fall, rise, m_rise);
            end
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
            tests_run++;
            if (evt !== m_evt || irq !== (|m_evt)) begin
                failed++; $display("FAIL random_evt n=%0d evt=%b/%b irq=%b/%b (got/exp)", n, evt, m_evt, irq, |m_evt);
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_clean_assert();
        test_glitch();
        test_x_indep();
`ifdef OD_BUS_RECEIVER_EVENT_LATCH_EN
        test_ack();
`endif
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/od_bus_receiver.md
# od_bus_receiver

Receive-side stage for the open-drain hex buffer lines in the AGC component models. It resolves each pulled-up wired-AND line to a clean logic level, synchronises it to `clk`, and rejects glitches shorter than a programmable number of cycles. It also reports filtered edges, and, when compiled in, latches assertion events until they are acknowledged. Its inputs connect directly to the `y1..y6` nets of open-drain drivers, and its outputs feed downstream clocked logic.

## Interface
- `CHANNELS`, default 6: number of independent open-drain lines.
- `FILTER`, default 3: consecutive synchronised cycles a new level must hold before it is accepted; legal range 1..15.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `vcc`, `gnd`  input  1 each  power pins; carried for netlist consistency, no logic function.
- `y`  input  CHANNELS  open-drain line values (may be 0, 1, z, x).
- `lvl`  output  CHANNELS  filtered line level.
- `fall`  output  CHANNELS  one-cycle pulse when `lvl` goes 1→0 (line asserted).
- `rise`  output  CHANNELS  one-cycle pulse when `lvl` goes 0→1 (line released).
- `ack`  input  CHANNELS  write-1-to-clear for `evt` (present only with event latch).
- `evt`  output  CHANNELS  sticky assertion flags (present only with event latch).
- `irq`  output  1  OR of `evt` (present only with event latch).

## Operation
- **Line resolution** (per bit, before sampling):
  - 0 → 0.
  - 1 or z → 1 (external pull-up).
  - x → 0 (contended line is treated as pulled low).
- **Synchroniser:** two-flop chain `s1`→`s2` per channel.
- **Filter:** per-channel counter `cnt`, width $clog2(FILTER+1).
  - When `s2 == lvl`, `cnt` is set to 0.
  - When `s2 != lvl` and `cnt == FILTER-1`, `lvl` takes `s2` and `cnt` is set to 0.
  - Otherwise `cnt` increments.
  - `cnt` never exceeds FILTER-1, so it cannot wrap.
- **Edge pulses:** `fall`/`rise` are registered and asserted for exactly one cycle, on the cycle after the edge at which `lvl` changed. They are never both high on the same channel.
- **Event latch:**
  - `evt[i]` sets on the edge where `lvl[i]` goes 1→0.
  - `evt[i]` clears on an edge with `ack[i]==1`.
  - If set and clear occur on the same edge, set wins.
  - `irq` is combinational OR of `evt`.
- **Channel independence:** channels are fully independent; simultaneous activity on any subset has no cross-effect.
- **Reset** (`rst==0` at a rising edge):
  - `s1`, `s2`, `lvl` go to all-ones (idle released bus).
  - `cnt` goes to 0.
  - `fall`, `rise`, `evt` go to 0; `irq` is therefore 0.
  - Reset overrides all other activity, including a filter count in progress and a pending `ack`.

## Timing
- **Latency:** a line level present at sampling edge n appears on `s2` after edge n+1. `lvl` changes at edge n+1+FILTER if the level holds through that edge. `fall`/`rise` appear after edge n+2+FILTER.
- **FILTER=1:** `lvl` follows `s2` one edge later (edge n+2) with no rejection.
- **Glitch rejection:** a pulse visible on `s2` for fewer than FILTER consecutive cycles never changes `lvl`, and `cnt` returns to 0.
- **Back-to-back edges:** a new edge can be accepted FILTER cycles after the previous one. Minimum `lvl` pulse width is FILTER cycles.
- **`ack`:** `ack` is sampled on the edge; `evt` falls the cycle after `ack` is applied. Holding `ack` high continuously still allows a new assertion to set `evt`, because set wins.
- **First release after reset:** release is idle, so no `rise` pulse follows reset while lines stay high. A line held low through reset produces `fall` at edge 2+FILTER after reset deasserts.

## Configuration
- Macro: `OD_BUS_RECEIVER_EVENT_LATCH_EN`.
- **Defined:** the `ack`, `evt` and `irq` ports and the sticky-flag logic exist as described.
- **Undefined:**
  - Those three ports and their registers are absent.
  - `lvl`, `fall` and `rise` behave identically to the defined case.

## Structure
- **Package `od_bus_pkg`:**
  - `OD_FILTER_MAX` = 15.
  - A `resolve_od` function (0/1/z/x → bit) per the resolution rules.
  - Typedef `od_cnt_t` sized for `OD_FILTER_MAX`.
- **Sub-module `od_rx_chan`:** one channel holding the synchroniser, filter counter, `lvl` register, edge pulses and optional `evt` bit.
- **Top level:** a generate loop instantiating CHANNELS copies of `od_rx_chan`, plus the `irq` reduction.

## Test plan
- **Reset state:** hold `rst=0` 3 cycles with `y`=all z → `lvl`=6'b111111, `fall`=`rise`=`evt`=0, `irq`=0.
- **Clean assertion:** with FILTER=3, drive `y[0]`=0 at edge 10 →
  - `lvl[0]` goes 0 after edge 14.
  - `fall[0]`=1 for exactly the cycle after edge 15.
  - `evt[0]`=1 and `irq`=1 from then on.
- **Glitch rejection:** drive `y[2]`=0 for 2 cycles, then z → `lvl[2]` stays 1, no `fall`/`rise`, `cnt` returns to 0.
- **x handling and independence:** `y[3]`=x and `y[4]`=0 simultaneously for 5 cycles → both `lvl` go 0 on the same edge, `fall[3]` and `fall[4]` pulse together, other channels are unaffected.
- **Ack and set priority:**
  - Assert `ack[0]` → `evt[0]` clears next cycle.
  - With `ack[1]` held high, assert `y[1]` → `evt[1]` still sets on the filtered fall.
- **Reset mid-filter:** drive `y[5]`=0, then pull `rst` low 2 cycles into the filter count → `lvl[5]`=1 and `cnt`=0 after reset. With `y[5]` still 0, `fall[5]` appears at edge 2+FILTER after reset release.
